ciphertext_packer: RTL and testbench
====================================

# ciphertext_packer

Final pipeline stage of NewHope-CPA encryption, directly downstream of the compress/encode stage. It captures the two byte streams that stage produces: EncodePoly(u) on the r1 port (896 B) and Compress(v'') on the r0 port (192 B). It double-buffers them so the next encryption can fill while the current one drains. It serialises ciphertext c = EncodePoly(u) || Compress(v'') (1088 B) over a valid/ready byte stream.

## Interface
- POLY_BYTES, 896, byte count of EncodePoly(u); occupies ciphertext bytes 0..895.
- COMP_BYTES, 192, byte count of Compress(v''); occupies ciphertext bytes 896..1087.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  pipeline enable; qualifies start_stage only.
- start_stage  in  1  one-cycle pulse; swaps banks and starts draining the just-filled bank.
- done_stage  out  1  one-cycle pulse after the last ciphertext byte is accepted.
- bwe_r0  in  1  write enable, compressed-v'' bytes.
- baddr_r0  in  8  byte address 0..COMP_BYTES-1.
- bdi_r0  in  8  byte data.
- bwe_r1  in  1  write enable, encoded-u bytes.
- baddr_r1  in  10  byte address 0..POLY_BYTES-1.
- bdi_r1  in  8  byte data.
- ct_valid  out  1  ct_data holds a valid byte.
- ct_ready  in  1  sink accepts the byte when ct_valid && ct_ready.
- ct_data  out  8  ciphertext byte.
- ct_last  out  1  high with byte index POLY_BYTES+COMP_BYTES-1.
- overrun  out  1  sticky; set when start_stage arrives while draining.

## Operation
- Storage: two banks per stream (u: 2×POLY_BYTES, v: 2×COMP_BYTES), 8-bit synchronous-read RAM, 1-cycle read latency.
- Bank select: reg rd_bank; write bank = ~rd_bank. Writes go to the write bank whenever bwe_* is high, independent of en and state. Out-of-range addresses are dropped.
- Accepted start = start_stage && en && state==IDLE. It toggles rd_bank, clears the byte index (11 bits), and enters STREAM.
- Rejected start = start_stage && en && state!=IDLE. It sets overrun. There is no bank swap and the drain continues undisturbed.
- FSM:
  - IDLE -> STREAM on accepted start.
  - STREAM issues reads in index order. Index < POLY_BYTES reads the u bank at index. Otherwise it reads the v bank at index-POLY_BYTES.
  - STREAM -> DONE when the byte with ct_last is accepted.
  - DONE: done_stage=1 for one cycle, then IDLE.
- Output buffer: 2-entry FIFO. A read is issued only when (occupancy + reads in flight) < 2, so no data is lost under backpressure. ct_valid = FIFO non-empty. ct_data and ct_last come from the FIFO head.
- ct_last is carried as a tag alongside each read, not derived from the index at output time.
- Reads stop once index reaches POLY_BYTES+COMP_BYTES. Any remaining FIFO entries drain normally.

## Timing
- Reset values:
  - outputs: ct_valid=0, ct_data=0, ct_last=0, done_stage=0, overrun=0.
  - internal: rd_bank=0 (write bank 1), state=IDLE, FIFO empty, index=0.
  - RAM contents are not reset.
- Latency: accepted start at cycle T. The first read is issued at T+1 and ct_valid rises at T+2.
- With ct_ready held high: one byte per cycle. The last byte is accepted at T+1089 and done_stage pulses at T+1090.
- ct_valid/ct_data/ct_last stay stable while ct_valid && !ct_ready.
- ct_ready low for k cycles stretches completion by exactly k cycles. No byte is duplicated or skipped.
- start_stage in the same cycle as the last acceptance: state is not IDLE, so the start is rejected and overrun is set.
- start_stage during the DONE cycle: rejected as well.
- Write to the write bank in the same cycle as an accepted start: the write lands in the old write bank, which becomes the read bank.
- rst mid-stream: immediate return to reset values. Partial output is abandoned and there is no done_stage.

## Structure
- Shared package holds: POLY_BYTES, COMP_BYTES, CT_BYTES = POLY_BYTES+COMP_BYTES (1088), the 11-bit index width, and the FSM state encoding (IDLE, STREAM, DONE).
- One sub-module, pingpong_byte_ram: parameter DEPTH; inputs swap, we, waddr, wdata, raddr; output rdata with 1-cycle latency. Two instances, one for u and one for v.
- Top level holds the FSM, index counter, in-flight tracking and the 2-entry FIFO.

## Test plan
- Fill write bank with u[i]=i[7:0] and v[j]=0xA0^j[7:0], start, ct_ready=1 -> bytes 0..895 = i mod 256, byte 896 = 0xA0, byte 1087 = 0xA0^0xBF = 0x1F, ct_last only on byte 1087, done_stage at T+1090.
- Same fill, ct_ready toggling 1,0,1,0 -> identical 1088-byte sequence, done_stage at T+1090+(number of ready-low cycles before last acceptance), data stable during stalls.
- Pipelined: during drain of set A, write set B (u=0x55, v=0xAA); second start after done -> output all 0x55 then all 0xAA, overrun=0.
- start_stage pulse at index 500 -> overrun=1 and sticky, stream completes unchanged, rd_bank unchanged.
- start_stage with en=0 -> nothing: ct_valid stays 0 and overrun stays 0.
- rst asserted at index 300 -> next cycle ct_valid=0, state IDLE, no done_stage. Refill and start -> full correct 1088-byte stream from bank 1.

Source files
------------

// File: rtl/ciphertext_packer_pkg.sv
// Shared constants and state encoding for the NewHope-CPA ciphertext packer.
// The ciphertext is EncodePoly(u) (POLY_BYTES) followed by Compress(v'') (COMP_BYTES).
package ciphertext_packer_pkg;
    localparam int POLY_BYTES = 896;
    localparam int COMP_BYTES = 192;
    localparam int CT_BYTES   = POLY_BYTES + COMP_BYTES;
    localparam int IDX_W      = 11;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t POLY_IDX = idx_t'(POLY_BYTES);
    localparam idx_t CT_IDX   = idx_t'(CT_BYTES);
    localparam idx_t LAST_IDX = idx_t'(CT_BYTES - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
endpackage

// File: rtl/ciphertext_packer_if.sv
// Valid/ready byte stream carrying the serialised ciphertext.
interface ciphertext_packer_if;
    logic       ct_valid;
    logic       ct_ready;
    logic [7:0] ct_data;
    logic       ct_last;

    modport master (output ct_valid, ct_data, ct_last, input ct_ready);
    modport slave  (input ct_valid, ct_data, ct_last, output ct_ready);
endinterface

// File: rtl/ciphertext_packer_pingpong_byte_ram.sv
// Two-bank byte RAM: one bank fills while the other is read; swap exchanges roles.
module pingpong_byte_ram #(
    parameter int DEPTH  = 896,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swap,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    localparam int AW = $clog2(2 * DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT  = ADDR_W'(DEPTH);
    localparam logic [AW-1:0]     OFFSET = AW'(DEPTH);

    logic [7:0]    mem [2*DEPTH];
    logic          rd_bank;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;

    // Writes always target the bank not being read.
    assign wa = AW'(waddr) + (rd_bank ? '0 : OFFSET);
    assign ra = AW'(raddr) + (rd_bank ? OFFSET : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank <= 1'b0;
        end else if (swap) begin
            rd_bank <= ~rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (we && waddr < LIMIT) begin
            mem[wa] <= wdata;
        end
        if (raddr < LIMIT) begin
            rdata <= mem[ra];
        end
    end
endmodule

// File: rtl/ciphertext_packer.sv
// Captures encoded u and compressed v'' into ping-pong banks and serialises
// c = EncodePoly(u) || Compress(v'') over a valid/ready byte stream.
module ciphertext_packer
    import ciphertext_packer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start_stage,
    output logic                done_stage,
    input  logic                bwe_r0,
    input  logic [7:0]          baddr_r0,
    input  logic [7:0]          bdi_r0,
    input  logic                bwe_r1,
    input  logic [9:0]          baddr_r1,
    input  logic [7:0]          bdi_r1,
    ciphertext_packer_if.master ct,
    output logic                overrun
);
    state_t     state, state_nx;
    idx_t       idx;
    logic       start_acc, start_rej, issue;
    logic       valid, last_out, pop, push, fifo_pop;
    logic       vld_p0, last_p0, sel_v_p0;
    logic [7:0] u_rdata, v_rdata, rd_data, data_out, v_raddr;
    logic [7:0] fifo_data [2];
    logic       fifo_last [2];
    logic       wptr, rptr;
    logic [1:0] occ;

    assign start_acc = start_stage && en && (state == IDLE);
    assign start_rej = start_stage && en && (state != IDLE);
    // Entries held plus the read in flight never exceed the two FIFO slots.
    assign issue     = (state == STREAM) && (idx < CT_IDX) && ((occ + {1'b0, vld_p0}) < 2'd2);
    assign v_raddr   = 8'(idx - POLY_IDX);

    pingpong_byte_ram #(.DEPTH(POLY_BYTES), .ADDR_W(10)) u_ram (
        .clk(clk), .rst(rst), .swap(start_acc),
        .we(bwe_r1), .waddr(baddr_r1), .wdata(bdi_r1),
        .raddr(idx[9:0]), .rdata(u_rdata)
    );

    pingpong_byte_ram #(.DEPTH(COMP_BYTES), .ADDR_W(8)) v_ram (
        .clk(clk), .rst(rst), .swap(start_acc),
        .we(bwe_r0), .waddr(baddr_r0), .wdata(bdi_r0),
        .raddr(v_raddr), .rdata(v_rdata)
    );

    // RAM output bypasses the FIFO when it is empty, so the head is either
    // the oldest stored entry or the byte arriving this cycle.
    assign rd_data  = sel_v_p0 ? v_rdata : u_rdata;
    assign valid    = (occ != 2'd0) || vld_p0;
    assign data_out = (occ != 2'd0) ? fifo_data[rptr] : (vld_p0 ? rd_data : 8'h00);
    assign last_out = (occ != 2'd0) ? fifo_last[rptr] : (vld_p0 && last_p0);
    assign pop      = valid && ct.ct_ready;
    assign fifo_pop = pop && (occ != 2'd0);
    assign push     = vld_p0 && !((occ == 2'd0) && pop);

    assign ct.ct_valid = valid;
    assign ct.ct_data  = data_out;
    assign ct.ct_last  = last_out;

    // Stage p0: read issued, tags travel with the RAM access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            occ     <= 2'd0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            if (start_acc) begin
                idx <= '0;
            end else if (issue) begin
                idx <= idx + idx_t'(1);
            end
            vld_p0  <= issue;
            last_p0 <= issue && (idx == LAST_IDX);
            if (push) wptr <= ~wptr;
            if (fifo_pop) rptr <= ~rptr;
            occ     <= occ + 2'(push) - 2'(fifo_pop);
            if (start_rej) overrun <= 1'b1;
        end
    end

    // Stage p1: RAM data lands in the output FIFO.
    always_ff @(posedge clk) begin
        sel_v_p0 <= (idx >= POLY_IDX);
        if (push) begin
            fifo_data[wptr] <= rd_data;
            fifo_last[wptr] <= last_p0;
        end
    end

    always_comb begin
        state_nx   = state;
        done_stage = 1'b0;
        case (state)
            IDLE:    if (start_acc) state_nx = STREAM;
            STREAM:  if (pop && last_out) state_nx = DONE;
            DONE: begin
                done_stage = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ciphertext_packer.sv
// Scoreboard bench for ciphertext_packer: a byte-level model of the two banks
// predicts each ciphertext; a monitor pops and compares every accepted byte.
module tb_ciphertext_packer;
    import ciphertext_packer_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic       clk, rst, en, start_stage, done_stage, overrun;
    logic       bwe_r0, bwe_r1;
    logic [7:0] baddr_r0, bdi_r0, bdi_r1;
    logic [9:0] baddr_r1;

    ciphertext_packer_if ct_bus();

    ciphertext_packer dut (
        .clk(clk), .rst(rst), .en(en), .start_stage(start_stage),
        .done_stage(done_stage),
        .bwe_r0(bwe_r0), .baddr_r0(baddr_r0), .bdi_r0(bdi_r0),
        .bwe_r1(bwe_r1), .baddr_r1(baddr_r1), .bdi_r1(bdi_r1),
        .ct(ct_bus), .overrun(overrun)
    );

    int vec = 0;
    int err = 0;
    int rdy_mode = 0;

    // Behavioural model state
    logic [7:0] mu [2][POLY_BYTES];
    logic [7:0] mv [2][COMP_BYTES];
    bit         m_bank, m_busy, m_overrun, last_seen;
    exp_t       sb[$];
    int         cyc, start_cyc, lows, acc_cnt, done_cnt;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ct_bus.ct_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       ct_bus.ct_ready = ~ct_bus.ct_ready;
                2:       ct_bus.ct_ready = 1'($urandom_range(0, 1));
                default: ct_bus.ct_ready = 1'b1;
            endcase
        end
    end

    // Monitor: tracks the model from observed stimulus and checks DUT outputs.
    initial begin
        exp_t e;
        cyc = 0; m_bank = 0; m_busy = 0; m_overrun = 0; last_seen = 0;
        start_cyc = 0; lows = 0; acc_cnt = 0; done_cnt = 0; prev_stall = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                m_bank = 0; m_busy = 0; m_overrun = 0; last_seen = 0;
                prev_stall = 0;
            end else begin
                chk("overrun", overrun, m_overrun);
                if (prev_stall) begin
                    chk("stall_valid", ct_bus.ct_valid, 1);
                    chk("stall_data", ct_bus.ct_data, prev_data);
                    chk("stall_last", ct_bus.ct_last, prev_last);
                end
                if (bwe_r1 && baddr_r1 < 10'(POLY_BYTES)) mu[!m_bank][baddr_r1] = bdi_r1;
                if (bwe_r0 && baddr_r0 < 8'(COMP_BYTES)) mv[!m_bank][baddr_r0] = bdi_r0;
                if (start_stage && en) begin
                    if (m_busy) begin
                        m_overrun = 1;
                    end else begin
                        m_bank = !m_bank;
                        m_busy = 1; last_seen = 0; lows = 0; acc_cnt = 0;
                        start_cyc = cyc;
                        for (int i = 0; i < CT_BYTES; i++) begin
                            e.d = (i < POLY_BYTES) ? mu[m_bank][i] : mv[m_bank][i - POLY_BYTES];
                            e.l = (i == CT_BYTES - 1);
                            sb.push_back(e);
                        end
                    end
                end
                if (ct_bus.ct_valid && ct_bus.ct_ready) begin
                    if (sb.size() == 0) begin
                        vec++; err++;
                        $display("FAIL spurious_byte: got %0h, expected no byte", ct_bus.ct_data);
                    end else begin
                        e = sb.pop_front();
                        chk("ct_data", ct_bus.ct_data, e.d);
                        chk("ct_last", ct_bus.ct_last, e.l);
                        acc_cnt++;
                        if (e.l) last_seen = 1;
                    end
                end
                if (m_busy && !last_seen && cyc >= start_cyc + 2 && !ct_bus.ct_ready) lows++;
                if (done_stage) begin
                    chk("done_expected", m_busy && last_seen, 1);
                    if (m_busy && last_seen) chk("done_cycle", cyc, start_cyc + 1090 + lows);
                    m_busy = 0;
                    done_cnt++;
                end
                prev_stall = ct_bus.ct_valid && !ct_bus.ct_ready;
                prev_data  = ct_bus.ct_data;
                prev_last  = ct_bus.ct_last;
            end
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < POLY_BYTES; i++) begin
            bwe_r1   = 1'b1;
            baddr_r1 = 10'(i);
            bdi_r1   = (mode == 0) ? 8'(i) : (mode == 1) ? 8'h55 : 8'($urandom);
            if (i < COMP_BYTES) begin
                bwe_r0   = 1'b1;
                baddr_r0 = 8'(i);
                bdi_r0   = (mode == 0) ? (8'hA0 ^ 8'(i)) : (mode == 1) ? 8'hAA : 8'($urandom);
            end else begin
                bwe_r0   = 1'($urandom_range(0, 1));
                baddr_r0 = 8'($urandom_range(COMP_BYTES, 255));
                bdi_r0   = 8'($urandom);
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            bwe_r0   = 1'b0;
            bwe_r1   = 1'b1;
            baddr_r1 = 10'($urandom_range(POLY_BYTES, 1023));
            bdi_r1   = 8'($urandom);
            tick();
        end
        bwe_r0 = 1'b0;
        bwe_r1 = 1'b0;
    endtask

    task automatic pulse_start;
        start_stage = 1'b1;
        tick();
        start_stage = 1'b0;
    endtask

    task automatic wait_done;
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < 5000) begin
            tick();
            n++;
        end
        chk("done_seen", done_cnt != d0, 1);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 5000) begin
            tick();
            n++;
        end
        chk("reach_index", acc_cnt >= target, 1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start_stage = 1'b0;
        bwe_r0 = 1'b0; baddr_r0 = '0; bdi_r0 = '0;
        bwe_r1 = 1'b0; baddr_r1 = '0; bdi_r1 = '0;
        repeat (3) tick();
        chk("rst_ct_valid", ct_bus.ct_valid, 0);
        chk("rst_ct_data", ct_bus.ct_data, 0);
        chk("rst_ct_last", ct_bus.ct_last, 0);
        chk("rst_done", done_stage, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // Ramp pattern, free-flowing sink
        rdy_mode = 0;
        fill(0);
        pulse_start();
        wait_done();

        // Same pattern under alternating backpressure
        fill(0);
        rdy_mode = 1;
        pulse_start();
        wait_done();
        rdy_mode = 0;

        // Next set fills while the current one drains
        fill(2);
        pulse_start();
        fill(1);
        wait_done();
        tick();
        pulse_start();
        wait_done();
        chk("pipelined_overrun", overrun, 0);

        // Start mid-drain is rejected and sticky
        fill(2);
        rdy_mode = 2;
        pulse_start();
        wait_acc(500);
        pulse_start();
        tick();
        chk("overrun_set", overrun, 1);
        wait_done();
        chk("overrun_sticky", overrun, 1);
        rdy_mode = 0;
        tick();
        // No refill: the read bank must be the one not swapped by the rejected start
        pulse_start();
        wait_done();

        // Start with en low does nothing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_overrun", overrun, 0);
        en = 1'b0;
        pulse_start();
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("en0_valid", ct_bus.ct_valid, 0);
            tick();
        end
        chk("en0_overrun", overrun, 0);

        // Reset mid-stream abandons output, then a fresh stream from bank 1
        fill(2);
        rdy_mode = 2;
        pulse_start();
        wait_acc(300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", ct_bus.ct_valid, 0);
        chk("midrst_done", done_stage, 0);
        chk("midrst_data", ct_bus.ct_data, 0);
        repeat (20) tick();
        fill(2);
        pulse_start();
        wait_done();
        rdy_mode = 0;
        repeat (5) tick();
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
